// File: rtl/key_filter.sv
// rtl/key_filter.sv - push-button synchroniser, debouncer and press-edge detector (optional long press under KEY_LONG_PRESS_EN)
module key_filter #(
    parameter int unsigned DEB_CNT  = 1_000_000,
    parameter int unsigned LONG_CNT = 50_000_000
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic key_in,
    output logic key_flag,
    output logic key_state,
    output logic key_long_flag
);

    localparam int unsigned DW = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        DOWN      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    state_t        state_q;
    logic [DW-1:0] cnt_q;
    logic          key_s1_q;
    logic          key_s2_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LW = (LONG_CNT > 2) ? $clog2(LONG_CNT) : 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);

    logic [LW-1:0] long_cnt_q;
    logic          long_done_q;
`endif

    // Two-flop synchroniser; idle level is released (1)
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
        end else begin
            key_s1_q <= key_in;
            key_s2_q <= key_s1_q;
        end
    end

    // Debounce FSM with registered press pulse, debounced level and long-press pulse
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_flag  <= 1'b0;
            key_state <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
            long_cnt_q    <= '0;
            long_done_q   <= 1'b0;
            key_long_flag <= 1'b0;
`endif
        end else begin
            key_flag <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            key_long_flag <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!key_s2_q) begin
                        state_q <= PRESS_DEB;
                        cnt_q   <= '0;
                    end
                end
                PRESS_DEB: begin
                    // A bounce on the final count still wins over acceptance
                    if (key_s2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= DOWN;
                        key_flag  <= 1'b1;
                        key_state <= 1'b0;
                        cnt_q     <= '0;
`ifdef KEY_LONG_PRESS_EN
                        long_cnt_q  <= '0;
                        long_done_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DOWN: begin
                    if (key_s2_q) begin
                        state_q <= REL_DEB;
                        cnt_q   <= '0;
                    end
`ifdef KEY_LONG_PRESS_EN
                    // Hold time keeps accumulating across release bounces; one pulse per press
                    if (!long_done_q) begin
                        if (long_cnt_q == LONG_LAST) begin
                            key_long_flag <= 1'b1;
                            long_done_q   <= 1'b1;
                        end else begin
                            long_cnt_q <= long_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                REL_DEB: begin
                    if (!key_s2_q) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= IDLE;
                        key_state <= 1'b1;
                        cnt_q     <= '0;
`ifdef KEY_LONG_PRESS_EN
                        long_cnt_q  <= '0;
                        long_done_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifndef KEY_LONG_PRESS_EN
    // No long-press detector in this build; LONG_CNT only appears so the expression folds to 0
    assign key_long_flag = (LONG_CNT == 0) && (LONG_CNT != 0);
`endif

endmodule

// File: doc/key_filter.md
# key_filter

Debounce and edge-detect stage for one mechanical push-button, sitting directly upstream of the LED toggle control. It synchronises the raw active-low key input, requires a stable level for a programmable number of clock cycles, and emits a single-cycle `key_flag` pulse per accepted press. That pulse feeds the downstream toggle's `key_flag` input. An optional long-press detector can be compiled in.

## Interface
- `DEB_CNT`, default 1_000_000: stability window in `sclk` cycles (20 ms at 50 MHz); legal range ≥ 2.
- `LONG_CNT`, default 50_000_000: hold time in cycles after press acceptance before `key_long_flag` fires (1 s at 50 MHz); used only with `KEY_LONG_PRESS_EN`.
- `sclk` input 1: system clock; the only clock.
- `s_rst_n` input 1: asynchronous, active-low reset.
- `key_in` input 1: raw button, active-low (0 = pressed), asynchronous to `sclk`.
- `key_flag` output 1: one-cycle pulse on each accepted press.
- `key_state` output 1: debounced level (1 = released, 0 = pressed).
- `key_long_flag` output 1: one-cycle pulse on each accepted long press; constant 0 without the macro.

## Operation
- Two-flop synchroniser `key_s1` → `key_s2`; both reset to 1. All decisions use `key_s2` only.
- The debounce counter width is sized to hold `DEB_CNT-1`; the long counter is sized to hold `LONG_CNT-1`. Counters never wrap in normal use, because each is cleared on state exit.
- The FSM has four states and resets to IDLE.
  - **IDLE**: the key is released.
    - If `key_s2==0`, go to PRESS_DEB and set cnt=0.
  - **PRESS_DEB**: waiting for a stable press.
    - If `key_s2==1`, a bounce occurred: go back to IDLE and set cnt=0.
    - Otherwise, if cnt==`DEB_CNT-1`, go to DOWN, pulse `key_flag`, set `key_state`=0 and set cnt=0.
    - Otherwise increment cnt.
  - **DOWN**: the press is accepted.
    - If `key_s2==1`, go to REL_DEB and set cnt=0.
  - **REL_DEB**: waiting for a stable release.
    - If `key_s2==0`, a bounce occurred: go back to DOWN. No new `key_flag` is produced.
    - Otherwise, if cnt==`DEB_CNT-1`, go to IDLE and set `key_state`=1.
    - Otherwise increment cnt.
- `key_flag` fires at most once per IDLE→DOWN transition. Release bounces never produce a flag.
- Reset values: `key_flag`=0, `key_state`=1, `key_long_flag`=0, cnt=0, long counter=0, state=IDLE.
- Reset asserted mid-operation aborts everything immediately.
  - A key still held when reset releases is treated as a new press.
  - That press yields `key_flag` after the full latency below.

## Timing
- All outputs are registered, with no combinational path from `key_in`.
- Press latency: let edge k be the first edge at which `key_s1` samples 0, with the input stable low from then on.
  - `key_s2`=0 after edge k+1.
  - PRESS_DEB is entered at edge k+2.
  - `key_flag`=1 and `key_state`=0 become valid after edge k+DEB_CNT+2.
  - `key_flag` is high for exactly one cycle.
- Release latency is the same: `key_state` returns to 1 after edge k+DEB_CNT+2, measured from the first edge sampling 1.
- A glitch shorter than `DEB_CNT` cycles, as seen at `key_s2`, is rejected entirely.
- A level change on the cycle cnt reaches `DEB_CNT-1` takes priority: the bounce branch wins and no acceptance occurs.

## Configuration
- Macro: `KEY_LONG_PRESS_EN`.
- **Defined**:
  - In DOWN, a long counter increments each cycle from 0, starting on DOWN entry.
  - When it reaches `LONG_CNT-1`, `key_long_flag` pulses for one cycle and the counter holds. There is one pulse per press and no auto-repeat.
  - The counter clears on entry to DOWN and on reaching IDLE. It also holds its value through REL_DEB.
  - A release bounce back to DOWN does not restart it.
- **Undefined**: the long counter is absent, and `key_long_flag` is driven constant 0. The port list is unchanged.

## Test plan
Bench parameters: `DEB_CNT`=10, `LONG_CNT`=40.
- **Reset**: hold `s_rst_n`=0 with `key_in`=1 → `key_flag`=0, `key_state`=1, `key_long_flag`=0.
- **Clean press**: drive `key_in` low and hold it for 30 cycles.
  - `key_flag` must be a single pulse, exactly 12 edges after the first edge that samples 0.
  - `key_state`=0 from that same edge.
- **Press bounce**: toggle `key_in` low for 5 cycles, high for 3, low for 5, then hold low.
  - No flag may appear during the bounce.
  - Exactly one `key_flag` must appear, 12 edges after the final low sample.
- **Release bounce**: from DOWN, go high for 4 cycles, low for 2, then high steadily.
  - No `key_flag` may appear.
  - `key_state` must return to 1 exactly 12 edges after the final high sample.
- **Reset mid-operation**: assert reset at cnt=6 in PRESS_DEB while `key_in` stays low.
  - Outputs must return to reset values immediately.
  - After release, `key_flag` must appear 12 edges after the first low sample.
- **`KEY_LONG_PRESS_EN` defined**: hold the key for 100 cycles.
  - `key_long_flag` must pulse exactly once, 40 cycles after `key_flag`.
  - With the macro undefined, `key_long_flag` must stay 0.
